core1_op_sequencer: RTL and testbench



---
 rtl/core1_pkg.sv | 23 ++
 rtl/core1_op_sequencer_core.sv | 23 ++
 rtl/core1_op_sequencer.sv | 81 ++++++++
 tb/tb_core1_op_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/core1_pkg.sv
// core1_pkg: opcodes, sequencer states, operand widths and masking helpers shared by the Core1 front-end.
package core1_pkg;
  localparam logic [2:0] OP_SQR  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_LUT  = 3'd3;
  localparam logic [2:0] OP_MASK = 3'd4;
  localparam int W_FULL = 256;
  localparam int W_HALF = 128;
  localparam int W_LUT  = 64;
  localparam int W_MASK = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} core1_seq_state_t;
  // Illegal opcodes mask to zero so the core never sees stale data.
  function automatic logic [W_FULL-1:0] mask_a(input logic [2:0] op, input logic [W_FULL-1:0] a);
    return op == OP_SQR ? W_FULL'(a[W_HALF-1:0]) :
           op == OP_XOR ? a :
           (op == OP_LUT || op == OP_MASK) ? W_FULL'(a[W_LUT-1:0]) : '0;
  endfunction
  function automatic logic [W_FULL-1:0] mask_b(input logic [2:0] op, input logic [W_FULL-1:0] b);
    return op == OP_XOR ? b :
           op == OP_LUT ? W_FULL'(b[W_LUT-1:0]) :
           op == OP_MASK ? W_FULL'(b[W_MASK-1:0]) : '0;
  endfunction
endpackage

// File: rtl/core1_op_sequencer_core.sv
// Core1_Implementation: combinational GF(2^m) core; SQR bit-spread, 256-bit XOR, 64x64 carry-less LUT multiply, byte MASK.
module Core1_Implementation
  import core1_pkg::*;
(
  input  logic [2:0]        sel,
  input  logic [W_FULL-1:0] a,
  input  logic [W_FULL-1:0] b,
  output logic [W_HALF-1:0] c,
  output logic [W_HALF-1:0] d
);
  logic [W_FULL-1:0] sq;
  logic [W_HALF-1:0] cl;
  always_comb begin
    sq = '0;
    cl = '0;
    for (int i = 0; i < W_HALF; i++) sq[2*i] = a[i];
    for (int i = 0; i < W_LUT; i++) cl = b[i] ? cl ^ (W_HALF'(a[W_LUT-1:0]) << i) : cl;
  end
  assign {c, d} = sel == OP_SQR  ? sq :
                  sel == OP_XOR  ? a ^ b :
                  sel == OP_LUT  ? {{W_HALF{1'b0}}, cl} :
                  sel == OP_MASK ? W_FULL'(a[W_LUT-1:0] & {8{b[W_MASK-1:0]}}) : '0;
endmodule

// File: rtl/core1_op_sequencer.sv
// core1_op_sequencer: valid/ready front-end registering masked operands into Core1 and holding its result.
// Optional perf counters perf_ops/perf_err enabled by CORE1_SEQ_PERF_CNT_EN.
module core1_op_sequencer
  import core1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [W_FULL-1:0] req_a,
  input  logic [W_FULL-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_FULL-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
`ifdef CORE1_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [15:0]       perf_err
`endif
);
  core1_seq_state_t state, state_nxt;
  logic [2:0] sel;
  logic [W_FULL-1:0] opa, opb;
  logic [W_HALF-1:0] c, d;
  logic legal, acc;
  assign legal = req_op inside {OP_SQR, OP_XOR, OP_LUT, OP_MASK};
  assign req_ready = state == ST_IDLE || (state == ST_DONE && rsp_ready);
  assign acc = req_valid && req_ready;
  assign rsp_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = legal ? ST_EXEC : ST_DONE;
    else if (state == ST_EXEC) state_nxt = ST_DONE;
    else if (state == ST_DONE && rsp_ready) state_nxt = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  // sel is non-zero only during EXEC, so the core is idle otherwise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel      <= '0;
      opa      <= '0;
      opb      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (acc) begin
      sel <= legal ? req_op : 3'd0;
      opa <= mask_a(req_op, req_a);
      opb <= mask_b(req_op, req_b);
      if (!legal) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end else if (state == ST_EXEC) begin
      sel      <= '0;
      rsp_data <= sel == OP_MASK ? W_FULL'(d[W_LUT-1:0]) : {c, d};
      rsp_err  <= 1'b0;
    end
  Core1_Implementation u_core (
    .sel (sel),
    .a   (opa),
    .b   (opb),
    .c   (c),
    .d   (d)
  );
`ifdef CORE1_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_ops <= '0;
      perf_err <= '0;
    end else begin
      if (state == ST_EXEC) perf_ops <= perf_ops + 32'd1;
      if (acc && !legal && perf_err != 16'hFFFF) perf_err <= perf_err + 16'd1;
    end
`endif
endmodule

// File: tb/tb_core1_op_sequencer.sv
// tb_core1_op_sequencer: directed self-checking bench for core1_op_sequencer.
module tb_core1_op_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [2:0] req_op = '0;
  logic [255:0] req_a = '0, req_b = '0, rsp_data;
  int checks = 0, failures = 0, ops_exp = 0, err_exp = 0;
`ifdef CORE1_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops;
  logic [15:0] perf_err;
`endif
  always #5 clk = ~clk;
  core1_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef CORE1_SEQ_PERF_CNT_EN
    ,
    .perf_ops  (perf_ops),
    .perf_err  (perf_err)
`endif
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'd1);
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'd0);
    chk({tag, "_rsp_data"}, rsp_data, 256'd0);
    chk({tag, "_rsp_err"}, 256'(rsp_err), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
`ifdef CORE1_SEQ_PERF_CNT_EN
    chk({tag, "_perf_ops"}, 256'(perf_ops), 256'd0);
    chk({tag, "_perf_err"}, 256'(perf_err), 256'd0);
`endif
  endtask
  // One full transaction from IDLE with rsp_ready=1, ending back in IDLE.
  task automatic xact(input string tag, input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                      input logic [255:0] exp_data, input logic exp_err);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    if (!exp_err) begin
      chk({tag, "_exec_valid"}, 256'(rsp_valid), 256'd0);
      chk({tag, "_exec_busy"}, 256'(busy), 256'd1);
      tick();
      ops_exp++;
    end else err_exp++;
    chk({tag, "_valid"}, 256'(rsp_valid), 256'd1);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"}, 256'(rsp_err), 256'(exp_err));
    tick();
    chk({tag, "_retired"}, 256'(rsp_valid), 256'd0);
  endtask
  initial begin
    logic [255:0] exp;
    #2;
    reset_vals("rst");
    tick();
    rst_n = 1'b1;
    tick();
    xact("xor", 3'd2, 256'h1, 256'h3, 256'h2, 1'b0);
    xact("sqr", 3'd1, 256'hF, 256'h0, 256'h55, 1'b0);
    xact("sqr_mask", 3'd1, {{128{1'b1}}, 128'hF}, {256{1'b1}}, 256'h55, 1'b0);
    xact("sqr_top", 3'd1, {128'h0, 1'b1, 127'h0}, 256'h0, {1'b1, 255'h0} >> 1, 1'b0);
    xact("lut", 3'd3, {192'hDEAD, 64'h3}, {192'hBEEF, 64'h3}, 256'h5, 1'b0);
    xact("mask", 3'd4, {192'hFFFF, 64'h1234_5678_9ABC_DEF0}, {248'h77, 8'h0F}, 256'h0204_0608_0A0C_0E00, 1'b0);
    xact("ill6", 3'd6, 256'h1, 256'h1, 256'h0, 1'b1);
    xact("ill0", 3'd0, 256'h7, 256'h7, 256'h0, 1'b1);
`ifdef CORE1_SEQ_PERF_CNT_EN
    chk("perf_err_ill", 256'(perf_err), 256'(err_exp));
`endif
    // Backpressure: hold rsp_ready low, response must stay put.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd2; req_a = 256'hAA; req_b = 256'h55;
    tick();
    req_valid = 1'b0;
    tick();
    ops_exp++;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 256'(rsp_valid), 256'd1);
      chk("hold_data", rsp_data, 256'hFF);
      chk("hold_req_ready", 256'(req_ready), 256'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd2; req_a = 256'h5; req_b = 256'h1;
    #1;
    chk("pulse_req_ready", 256'(req_ready), 256'd1);
    tick();
    req_valid = 1'b0;
    chk("pulse_exec_valid", 256'(rsp_valid), 256'd0);
    chk("pulse_busy", 256'(busy), 256'd1);
    tick();
    ops_exp++;
    chk("pulse_valid", 256'(rsp_valid), 256'd1);
    chk("pulse_data", rsp_data, 256'h4);
    tick();
    // Back-to-back stream through DONE->EXEC.
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_op = 3'd2;
      req_a = 256'(k + 1) << (8 * k); req_b = 256'(k);
      exp = req_a ^ req_b;
      tick();
      chk("stream_exec_valid", 256'(rsp_valid), 256'd0);
      tick();
      ops_exp++;
      chk("stream_valid", 256'(rsp_valid), 256'd1);
      chk("stream_data", rsp_data, exp);
    end
    req_valid = 1'b0;
    tick();
    chk("stream_idle", 256'(busy), 256'd0);
`ifdef CORE1_SEQ_PERF_CNT_EN
    chk("perf_ops", 256'(perf_ops), 256'(ops_exp));
    chk("perf_err", 256'(perf_err), 256'(err_exp));
`endif
    // Asynchronous reset during EXEC discards the operation.
    req_valid = 1'b1; req_op = 3'd2; req_a = 256'h10; req_b = 256'h01;
    tick();
    req_valid = 1'b0;
    chk("mid_busy", 256'(busy), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("mid_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 256'(rsp_valid), 256'd0);
    end
    chk("post_rst_data", rsp_data, 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
